// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and a held-state bit per mapped key.
// Raw PS/2 lines are synchronised, 11-bit frames are deframed on falling clock edges,
// and every good byte drives a small decoder that tracks make/break codes.
module ps2_key_tracker #(
  parameter int                      NUM_KEYS    = 6,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES   = 48'h2D_29_23_1B_1C_1D,
  parameter logic [NUM_KEYS-1:0]     KEY_EXT     = '0,
  parameter int                      SYNC_STAGES = 2,
  parameter int                      TIMEOUT_CYC = 50000
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  output logic [NUM_KEYS-1:0] key_status,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [7:0]          scan_code,
  output logic                scan_ready,
  output logic                frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                  clk_prev;
  logic                  clk_s, dat_s, fe;
  logic [7:0]            shift;
  logic [2:0]            cnt;
  logic                  par_bit;
  logic [TW-1:0]         tmo;
  logic                  tmo_hit;
  logic                  start_err, frame_good, frame_bad, timeout;
  logic                  brk, ext;
  logic [NUM_KEYS-1:0]   status_next;

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign fe      = clk_prev & ~clk_s;
  assign tmo_hit = (tmo == TW'(TIMEOUT_CYC - 1));

  // Synchronise both PS/2 lines; they reset to the idle-high level so no false edge appears.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Receiver next-state and per-frame event decode.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_next = state;
    start_err  = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: if (fe) begin
        if (!dat_s) state_next = DATA;
        else        start_err  = 1'b1;
      end
      DATA:   if (fe && cnt == 3'd7) state_next = PARITY;
      PARITY: if (fe) state_next = STOP;
      STOP: if (fe) begin
        state_next = IDLE;
        if (dat_s && (^{shift, par_bit})) frame_good = 1'b1;
        else                              frame_bad  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // A stalled frame is abandoned; a falling edge in the same cycle keeps it alive.
    if (state != IDLE && !fe && tmo_hit) begin
      timeout    = 1'b1;
      state_next = IDLE;
    end
  end

  // Receiver datapath: bit shifter, counters and the registered frame results.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      cnt        <= '0;
      par_bit    <= 1'b0;
      tmo        <= '0;
      scan_code  <= '0;
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state_next == IDLE || fe) tmo <= '0;
      else                          tmo <= tmo + TW'(1);
      if (fe) begin
        case (state)
          IDLE:   cnt <= '0;
          DATA: begin
            shift <= {dat_s, shift[7:1]};
            cnt   <= cnt + 3'd1;
          end
          PARITY: par_bit <= dat_s;
          default: ;
        endcase
      end
      scan_ready <= frame_good;
      frame_err  <= start_err | frame_bad | timeout;
      if (frame_good) scan_code <= shift;
    end
  end

  // Key map lookup: matching entries take the make/break value of the current byte.
  always_comb begin
    status_next = key_status;
    if (scan_ready && scan_code != 8'hE0 && scan_code != 8'hF0) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (KEY_CODES[8*i +: 8] == scan_code && KEY_EXT[i] == ext) status_next[i] = ~brk;
      end
    end
  end

  // Prefix flags, held-key state and press pulses.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      brk        <= 1'b0;
      ext        <= 1'b0;
      key_status <= '0;
      key_press  <= '0;
    end else begin
      key_status <= status_next;
      key_press  <= status_next & ~key_status;
      if (scan_ready) begin
        if (scan_code == 8'hE0)      ext <= 1'b1;
        else if (scan_code == 8'hF0) brk <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a table of frames with expected key state,
// plus hand-written timeout, failed-prefix and mid-frame reset sequences.
module tb_ps2_key_tracker;

  logic       CLOCK_50 = 1'b0;
  logic       rst      = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic [5:0] key_status, key_press;
  logic [7:0] scan_code;
  logic       scan_ready, frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse observers, sampled on the falling system clock edge.
  int         sr_total  = 0;
  int         err_total = 0;
  int         kp_total  = 0;
  logic [5:0] kp_last   = '0;

  logic [5:0] model_status = '0;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [5:0] exp_status;
    logic [7:0] exp_scan;
    int         exp_sr;
    int         exp_err;
    int         exp_kp;
  } vec_t;

  vec_t vecs[14];

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_key_tracker #(
    .NUM_KEYS   (6),
    .KEY_CODES  (48'h75_29_23_1B_1C_1D),
    .KEY_EXT    (6'b100000),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(50000)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .key_status(key_status),
    .key_press (key_press),
    .scan_code (scan_code),
    .scan_ready(scan_ready),
    .frame_err (frame_err)
  );

  always @(negedge CLOCK_50) begin
    if (scan_ready) sr_total++;
    if (frame_err)  err_total++;
    if (key_press != 6'b0) begin
      kp_total++;
      kp_last = key_press;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the first nbits of a frame (start, 8 data LSB-first, odd parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (5) @(negedge CLOCK_50);
      ps2_clk = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      ps2_clk = 1'b1;
      repeat (5) @(negedge CLOCK_50);
    end
    ps2_dat = 1'b1;
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int sr0, err0, kp0;
    sr0  = sr_total;
    err0 = err_total;
    kp0  = kp_total;
    send_frame(v.code, v.bad_par, v.bad_stop, 11);
    check({tag, " status"},     32'(key_status),     32'(v.exp_status));
    check({tag, " scan_code"},  32'(scan_code),      32'(v.exp_scan));
    check({tag, " scan_ready"}, sr_total - sr0,      v.exp_sr);
    check({tag, " frame_err"},  err_total - err0,    v.exp_err);
    check({tag, " key_press"},  kp_total - kp0,      v.exp_kp);
    if (v.exp_kp != 0)
      check({tag, " press_bits"}, 32'(kp_last), 32'(v.exp_status & ~model_status));
    model_status = v.exp_status;
  endtask

  initial begin
    int err0, sr0;
    vec_t v;

    //            code   bpar  bstop status      scan   sr err kp
    vecs[0]  = '{8'h1D, 1'b0, 1'b0, 6'b000001, 8'h1D, 1, 0, 1};  // W make
    vecs[1]  = '{8'h1D, 1'b0, 1'b0, 6'b000001, 8'h1D, 1, 0, 0};  // typematic repeat
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 6'b000001, 8'hF0, 1, 0, 0};
    vecs[3]  = '{8'h1D, 1'b0, 1'b0, 6'b000000, 8'h1D, 1, 0, 0};  // W break
    vecs[4]  = '{8'h75, 1'b0, 1'b0, 6'b000000, 8'h75, 1, 0, 0};  // needs E0
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 6'b000000, 8'hE0, 1, 0, 0};
    vecs[6]  = '{8'h75, 1'b0, 1'b0, 6'b100000, 8'h75, 1, 0, 1};  // extended make
    vecs[7]  = '{8'hE0, 1'b0, 1'b0, 6'b100000, 8'hE0, 1, 0, 0};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 6'b100000, 8'hF0, 1, 0, 0};
    vecs[9]  = '{8'h75, 1'b0, 1'b0, 6'b000000, 8'h75, 1, 0, 0};  // extended break
    vecs[10] = '{8'h1C, 1'b1, 1'b0, 6'b000000, 8'h75, 0, 1, 0};  // bad parity
    vecs[11] = '{8'h1C, 1'b0, 1'b0, 6'b000010, 8'h1C, 1, 0, 1};  // A
    vecs[12] = '{8'h23, 1'b0, 1'b0, 6'b001010, 8'h23, 1, 0, 1};  // D, A still held
    vecs[13] = '{8'h1B, 1'b0, 1'b1, 6'b001010, 8'h23, 0, 1, 0};  // bad stop bit

    repeat (5) @(negedge CLOCK_50);
    check("reset status",     32'(key_status), 32'h0);
    check("reset press",      32'(key_press),  32'h0);
    check("reset scan_code",  32'(scan_code),  32'h0);
    check("reset scan_ready", 32'(scan_ready), 32'h0);
    check("reset frame_err",  32'(frame_err),  32'h0);
    rst = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Frame stalls after 4 data bits: no error well before the limit, one error after it.
    err0 = err_total;
    sr0  = sr_total;
    send_frame(8'h1B, 1'b0, 1'b0, 5);
    repeat (49000) @(negedge CLOCK_50);
    check("timeout early", err_total - err0, 0);
    repeat (1100) @(negedge CLOCK_50);
    check("timeout err",   err_total - err0, 1);
    check("timeout no sr", sr_total - sr0,   0);
    check("timeout keys",  32'(key_status),  32'(model_status));
    v = '{8'h1B, 1'b0, 1'b0, 6'b001110, 8'h1B, 1, 0, 1};
    run_vec(v, "post_timeout S");

    // A break prefix whose frame fails must not arm brk for the next byte.
    v = '{8'h1D, 1'b0, 1'b0, 6'b001111, 8'h1D, 1, 0, 1};
    run_vec(v, "W make");
    v = '{8'hF0, 1'b1, 1'b0, 6'b001111, 8'h1D, 0, 1, 0};
    run_vec(v, "bad F0");
    v = '{8'h1D, 1'b0, 1'b0, 6'b001111, 8'h1D, 1, 0, 0};
    run_vec(v, "W after bad F0");
    v = '{8'hF0, 1'b0, 1'b0, 6'b001111, 8'hF0, 1, 0, 0};
    run_vec(v, "good F0");
    v = '{8'h1D, 1'b0, 1'b0, 6'b001110, 8'h1D, 1, 0, 0};
    run_vec(v, "W break");

    // Reset in the middle of a frame, then a clean frame decodes normally.
    send_frame(8'h29, 1'b0, 1'b0, 4);
    rst = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("midrst status",     32'(key_status), 32'h0);
    check("midrst scan_code",  32'(scan_code),  32'h0);
    check("midrst scan_ready", 32'(scan_ready), 32'h0);
    check("midrst frame_err",  32'(frame_err),  32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b0;
    model_status = '0;
    repeat (5) @(negedge CLOCK_50);
    v = '{8'h1C, 1'b0, 1'b0, 6'b000010, 8'h1C, 1, 0, 1};
    run_vec(v, "post_reset A");
    v = '{8'h23, 1'b0, 1'b0, 6'b001010, 8'h23, 1, 0, 1};
    run_vec(v, "post_reset D");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
